// File: rtl/fifo_push_packer.sv
// Purpose : packs up to 4 source words per cycle into lanes 0..G-1 of 4 downstream FIFO banks, round-robin fair, credit-limited.
// Latency : 1 cycle from acceptance (in_k_valid & in_k_ready) to push_k / push_k_data.
// Backpres: in_k_ready is combinational from valids + state; grants stop once credits_r free entries are used up this cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_k_valid/data/ready    source k offer, payload, accept strobe (k = 0..3)
//   push_k / push_k_data     registered push strobe and payload for downstream lane k
//   pop_ret                  one downstream entry freed; returns a credit next cycle
//   credits_r                registered count of free downstream entries (0..4*N)
//   stall_cnt_r              only with FIFO_PUSH_PACKER_STALL_CNT_EN: saturating count of cycles
//                            in which some source was valid but not accepted
module fifo_push_packer #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_0_valid,
  input  logic [W-1:0]          in_0_data,
  output logic                  in_0_ready,
  input  logic                  in_1_valid,
  input  logic [W-1:0]          in_1_data,
  output logic                  in_1_ready,
  input  logic                  in_2_valid,
  input  logic [W-1:0]          in_2_data,
  output logic                  in_2_ready,
  input  logic                  in_3_valid,
  input  logic [W-1:0]          in_3_data,
  output logic                  in_3_ready,
  output logic                  push_0,
  output logic [W-1:0]          push_0_data,
  output logic                  push_1,
  output logic [W-1:0]          push_1_data,
  output logic                  push_2,
  output logic [W-1:0]          push_2_data,
  output logic                  push_3,
  output logic [W-1:0]          push_3_data,
  input  logic                  pop_ret,
`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
  output logic [15:0]           stall_cnt_r,
`endif
  output logic [$clog2(4*N):0]  credits_r
);

  localparam int C  = 4 * N;
  localparam int CW = $clog2(C) + 1;

  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [W-1:0] data [4];

  logic [1:0]   rr_ptr_r;
  logic [1:0]   rr_next;
  logic [1:0]   idx;
  logic [2:0]   avail;
  logic [2:0]   g_cnt;
  logic [3:0]   lane_vld;
  logic [W-1:0] lane_dat [4];

  logic [CW:0]  credit_sum;
  logic         overflow;

  logic [3:0]   push_r;
  logic [W-1:0] push_dat_r [4];

  assign valid   = {in_3_valid, in_2_valid, in_1_valid, in_0_valid};
  assign data[0] = in_0_data;
  assign data[1] = in_1_data;
  assign data[2] = in_2_data;
  assign data[3] = in_3_data;

  assign in_0_ready = ready[0];
  assign in_1_ready = ready[1];
  assign in_2_ready = ready[2];
  assign in_3_ready = ready[3];

  assign push_0      = push_r[0];
  assign push_1      = push_r[1];
  assign push_2      = push_r[2];
  assign push_3      = push_r[3];
  assign push_0_data = push_dat_r[0];
  assign push_1_data = push_dat_r[1];
  assign push_2_data = push_dat_r[2];
  assign push_3_data = push_dat_r[3];

  // Grant scan: walk sources from rr_ptr_r, granting each valid one while
  // credits remain. The running grant count doubles as the lane index, so
  // granted words land contiguously in lanes 0..G-1 and lanes never have holes.
  // rst gates the grants so nothing is accepted while reset is held.
  always_comb begin
    ready    = '0;
    lane_vld = '0;
    g_cnt    = '0;
    rr_next  = rr_ptr_r;
    idx      = '0;
    for (int i = 0; i < 4; i++) lane_dat[i] = '0;
    avail = (credits_r >= CW'(4)) ? 3'd4 : 3'(credits_r);
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_r + 2'(i);
      if (rst && valid[idx] && (g_cnt < avail)) begin
        ready[idx]              = 1'b1;
        lane_vld[g_cnt[1:0]]    = 1'b1;
        lane_dat[g_cnt[1:0]]    = data[idx];
        g_cnt                   = g_cnt + 3'd1;
        rr_next                 = idx + 2'd1;
      end
    end
  end

  // Credits are consumed at acceptance; a returned credit lands next cycle.
  assign credit_sum = {1'b0, credits_r} - {{(CW-2){1'b0}}, g_cnt} + {{CW{1'b0}}, pop_ret};
  assign overflow   = credit_sum > (CW+1)'(C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_r    <= '0;
      credits_r <= CW'(C);
      rr_ptr_r  <= '0;
    end else begin
      push_r    <= lane_vld;
      credits_r <= overflow ? CW'(C) : credit_sum[CW-1:0];
      rr_ptr_r  <= rr_next;
    end
  end

  // Payload is qualified by push_r, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) push_dat_r[i] <= lane_dat[i];
  end

`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
  logic stall;
  assign stall = |(valid & ~ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
    end else if (stall && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A credit return with every downstream entry already free means the
  // downstream popped something it was never pushed.
  credit_overflow_a: assert property (@(posedge clk) disable iff (!rst) !overflow);
`endif

endmodule

// File: tb/tb_fifo_push_packer.sv
module tb_fifo_push_packer;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int C  = 4 * N;
  localparam int CW = $clog2(C) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    v   = '0;
  logic [W-1:0]  dat [4];
  logic          pop = 1'b0;

  logic          in_0_ready, in_1_ready, in_2_ready, in_3_ready;
  logic          push_0, push_1, push_2, push_3;
  logic [W-1:0]  push_0_data, push_1_data, push_2_data, push_3_data;
  logic [CW-1:0] credits_r;
`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
  logic [15:0]   stall_cnt_r;
`endif

  logic [3:0]    rdy;
  logic [3:0]    push_v;
  logic [W-1:0]  pdat [4];

  assign rdy     = {in_3_ready, in_2_ready, in_1_ready, in_0_ready};
  assign push_v  = {push_3, push_2, push_1, push_0};
  assign pdat[0] = push_0_data;
  assign pdat[1] = push_1_data;
  assign pdat[2] = push_2_data;
  assign pdat[3] = push_3_data;

  fifo_push_packer #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_0_valid  (v[0]),
    .in_0_data   (dat[0]),
    .in_0_ready  (in_0_ready),
    .in_1_valid  (v[1]),
    .in_1_data   (dat[1]),
    .in_1_ready  (in_1_ready),
    .in_2_valid  (v[2]),
    .in_2_data   (dat[2]),
    .in_2_ready  (in_2_ready),
    .in_3_valid  (v[3]),
    .in_3_data   (dat[3]),
    .in_3_ready  (in_3_ready),
    .push_0      (push_0),
    .push_0_data (push_0_data),
    .push_1      (push_1),
    .push_1_data (push_1_data),
    .push_2      (push_2),
    .push_2_data (push_2_data),
    .push_3      (push_3),
    .push_3_data (push_3_data),
    .pop_ret     (pop),
`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
    .stall_cnt_r (stall_cnt_r),
`endif
    .credits_r   (credits_r)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: free downstream entries, scan start, stall count.
  int credits_m = C;
  int rr_m      = 0;
  int stall_m   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_dat();
    for (int i = 0; i < 4; i++) dat[i] = $urandom;
  endtask

  // Entered just after a falling edge; asserts reset, checks reset values
  // while sources may still be offering, releases on the next falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_push", 64'(push_v), 64'd0);
    chk("reset_credits", 64'(credits_r), 64'(C));
    chk("reset_ready", 64'(rdy), 64'd0);
    chk("reset_rr", 64'(dut.rr_ptr_r), 64'd0);
`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
    chk("reset_stall", 64'(stall_cnt_r), 64'd0);
`endif
    credits_m = C;
    rr_m      = 0;
    stall_m   = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive sources, predict grants from the rotating scan over the
  // valid set, check readies before the edge and pushes/state after it.
  task automatic step(input logic [3:0] vin, input logic pop_req);
    int         q[$];
    int         g;
    int         s;
    logic [3:0] er;
    v = vin;
    for (int i = 0; i < 4; i++) begin
      s = (rr_m + i) % 4;
      if (vin[s]) q.push_back(s);
    end
    g = q.size();
    if (g > credits_m) g = credits_m;
    er = '0;
    for (int j = 0; j < g; j++) er[q[j]] = 1'b1;
    pop = pop_req && ((credits_m - g) < C);
    #1;
    chk("ready", 64'(rdy), 64'(er));
    @(posedge clk);
    #1;
    chk("push", 64'(push_v), 64'((1 << g) - 1));
    for (int j = 0; j < g; j++) chk("push_data", 64'(pdat[j]), 64'(dat[q[j]]));
    credits_m = credits_m - g + int'(pop);
    if (g > 0) rr_m = (q[g-1] + 1) % 4;
    if (|(vin & ~er) && stall_m < 65535) stall_m++;
    chk("credits", 64'(credits_r), 64'(credits_m));
    chk("rr_ptr", 64'(dut.rr_ptr_r), 64'(rr_m));
`ifdef FIFO_PUSH_PACKER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt_r), 64'(stall_m));
`endif
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    rand_dat();
    @(negedge clk);
    do_reset();

    // Two sparse sources packed into lanes 0 and 1.
    dat[1] = 32'hA;
    dat[3] = 32'hB;
    step(4'b1010, 1'b0);
    chk("sparse_push", 64'(push_v), 64'b0011);
    chk("sparse_lane0", 64'(push_0_data), 64'hA);
    chk("sparse_lane1", 64'(push_1_data), 64'hB);
    chk("sparse_credits", 64'(credits_r), 64'd30);
    chk("sparse_rr", 64'(dut.rr_ptr_r), 64'd0);

    // Full-rate drain to zero credits.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_dat();
      step(4'hF, 1'b0);
    end
    chk("drain_credits", 64'(credits_r), 64'd0);
    chk("drain_ready", 64'(rdy), 64'd0);
    step(4'hF, 1'b0);
    chk("drain_ninth_push", 64'(push_v), 64'd0);

    // Two credits left with scan starting at source 3: wraps to source 0.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      rand_dat();
      step(4'hF, 1'b0);
    end
    step(4'b0111, 1'b0);
    step(4'b0000, 1'b1);
    chk("wrap_pre_credits", 64'(credits_r), 64'd2);
    chk("wrap_pre_rr", 64'(dut.rr_ptr_r), 64'd3);
    rand_dat();
    step(4'hF, 1'b0);
    chk("wrap_push", 64'(push_v), 64'b0011);
    chk("wrap_lane0", 64'(push_0_data), 64'(dat[3]));
    chk("wrap_lane1", 64'(push_1_data), 64'(dat[0]));
    chk("wrap_credits", 64'(credits_r), 64'd0);
    chk("wrap_rr", 64'(dut.rr_ptr_r), 64'd1);

    // Credit return at zero is only usable a cycle later.
    step(4'b0001, 1'b1);
    chk("zero_pop_push", 64'(push_v), 64'd0);
    chk("zero_pop_credits", 64'(credits_r), 64'd1);
    step(4'b0001, 1'b0);
    chk("zero_pop_grant", 64'(push_v), 64'b0001);
    chk("zero_pop_after", 64'(credits_r), 64'd0);

    // Three grants and a return together.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rand_dat();
      step(4'hF, 1'b0);
    end
    step(4'b0011, 1'b0);
    chk("g3_pre_credits", 64'(credits_r), 64'd10);
    step(4'b0111, 1'b1);
    chk("g3_credits", 64'(credits_r), 64'd8);
    chk("g3_push", 64'(push_v), 64'b0111);

    // Reset asserted while a full burst is pushing.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rand_dat();
      step(4'hF, 1'b0);
    end
    do_reset();

    // Randomized traffic with varying return pressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rand_dat();
      if (k % 700 == 699) begin
        v = 4'($urandom);
        do_reset();
      end else begin
        step(4'($urandom), (($urandom % 8) < ((k / 300) % 8)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_push_packer.md
FIFO_PUSH_PACKER -- requirements
Module: fifo_push_packer

Interface
REQ-001 SHALL have parameter W, default 32, the payload width in bits.
REQ-002 SHALL have parameter N, default 8, the depth of each of the 4 downstream FIFO banks, giving a total capacity C = 4*N.
REQ-003 SHALL have port clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports in_k_valid  input  1  source k (k=0..3) offers a word.
REQ-006 SHALL have ports in_k_data  input  W  source k payload.
REQ-007 SHALL have ports in_k_ready  output  1  source k word accepted this cycle (combinational).
REQ-008 SHALL have ports push_k  output  1  registered push strobe for downstream lane k.
REQ-009 SHALL have ports push_k_data  output  W  registered lane k payload.
REQ-010 SHALL have port pop_ret  input  1  one entry freed downstream (driven by the downstream pop valid).
REQ-011 SHALL have port credits_r  output  $clog2(C)+1  registered count of free downstream entries.

Function
REQ-012 SHALL accept in_k only when in_k_valid=1 and in_k_ready=1; ready SHALL NOT depend on any input except the in_*_valid inputs and internal state.
REQ-013 SHALL scan sources in rotating order starting at rr_ptr_r (0..3, wrapping 3->0) and grant the first G valid sources, where G = min(credits_r, 4, number of valid sources).
REQ-014 SHALL pack granted words contiguously into lanes 0..G-1 in scan order; lanes G..3 SHALL have push_k=0 in the following cycle.
REQ-015 SHALL register push_k and push_k_data one cycle after acceptance (latency 1); push_k_data of non-pushed lanes is don't-care.
REQ-016 SHALL never assert push_j when some push_i with i<j is deasserted.
REQ-017 SHALL update credits_r_next = credits_r - G + pop_ret each cycle; decrement SHALL apply at acceptance, not at push.
REQ-018 SHALL keep credits_r within 0..C; a pop_ret that would raise credits above C SHALL be an assertion failure, with credits held at C.
REQ-019 SHALL, when G>0, set rr_ptr_r to (index of last granted source + 1) mod 4; when G=0, rr_ptr_r SHALL hold.
REQ-020 SHALL, when credits_r=0, deassert all in_k_ready; a simultaneous pop_ret SHALL take effect the next cycle only.
REQ-021 SHALL, when all 4 sources are valid and credits_r>=4, grant all 4 in one cycle, starting lane 0 at rr_ptr_r.

Reset
REQ-022 SHALL, on rst=0, asynchronously force push_k=0, credits_r=C, and rr_ptr_r=0; push_k_data need not be reset.
REQ-023 SHALL drop words accepted in the cycle reset asserts; they SHALL NOT appear on push_k.
REQ-024 SHALL accept no input while rst=0 (all in_k_ready=0).

Configuration
REQ-025 SHALL, with macro FIFO_PUSH_PACKER_STALL_CNT_EN defined, add output stall_cnt_r (16 bits, reset 0) that increments (saturating at 16'hFFFF) each cycle in which any in_k_valid=1 with in_k_ready=0.
REQ-026 SHALL, without FIFO_PUSH_PACKER_STALL_CNT_EN, omit the stall_cnt_r port and its logic entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover: reset release, then in_1 and in_3 valid with data 0xA,0xB and credits 32 -> next cycle push_0=1/0xA, push_1=1/0xB, push_2=push_3=0; credits_r=30; rr_ptr_r=0.
REQ-028 SHALL cover: all 4 valid every cycle with no pop_ret -> 8 cycles of 4 pushes; credits_r reaches 0; ninth cycle all ready=0.
REQ-029 SHALL cover: credits_r=2, all 4 valid, rr_ptr_r=3 -> in_3 and in_0 granted, packed into lanes 0 and 1; rr_ptr_r becomes 1; credits_r=0.
REQ-030 SHALL cover: credits_r=0 with pop_ret=1 and in_0 valid -> in_0_ready=0 this cycle; next cycle credits_r=1 and in_0 granted.
REQ-031 SHALL cover: G=3 with pop_ret=1 at credits_r=10 -> credits_r=8.
REQ-032 SHALL cover: rst asserted mid-burst -> push_k=0 immediately, credits_r=32; with the macro defined, stall_cnt_r=0.
